// File: rtl/noc_sink_pkg.sv
// Shared constants for the NoC packet sink: flit marker values, flit field
// bit positions (64-bit flit layout), FSM state encoding and pkt_err bit
// indices.
package noc_sink_pkg;

   localparam logic [7:0] HEAD_H = 8'hA5;
   localparam logic [7:0] HEAD_E = 8'h5A;
   localparam logic [7:0] TAIL_H = 8'hC3;
   localparam logic [7:0] TAIL_E = 8'h3C;

   // LSB position of each flit field
   localparam int POS_MARK_H = 56;
   localparam int POS_SRC_X  = 52;
   localparam int POS_SRC_Y  = 48;
   localparam int POS_DST_X  = 44;
   localparam int POS_DST_Y  = 40;
   localparam int POS_TYPE   = 38;
   localparam int POS_ORDER  = 34;
   localparam int POS_LEN    = 26;
   localparam int POS_MARK_E = 18;

   localparam logic [1:0] IDLE      = 2'd0;
   localparam logic [1:0] BODY      = 2'd1;
   localparam logic [1:0] WAIT_TAIL = 2'd2;
   localparam logic [1:0] DROP      = 2'd3;

   // pkt_err = {err_tail, err_len, err_dest, err_hdr}
   localparam int ERR_HDR  = 0;
   localparam int ERR_DEST = 1;
   localparam int ERR_LEN  = 2;
   localparam int ERR_TAIL = 3;

endpackage

// File: rtl/noc_skid_buffer.sv
// Two-entry payload buffer between the sink FSM and the local consumer.
// Ports:
//   i_clk, i_rst        clock, asynchronous active-high reset
//   i_valid, i_data     push side (i_valid must only be raised while o_ready)
//   o_ready             space available; low during reset and until the first
//                       clock edge after reset release
//   o_valid, o_data     registered output stream, held until i_ready
//   i_ready             consumer accept
module noc_skid_buffer #(
   parameter int W = 65
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_valid,
   input  logic [W-1:0] i_data,
   output logic         o_ready,
   output logic         o_valid,
   output logic [W-1:0] o_data,
   input  logic         i_ready
);

   logic [W-1:0] r_mem [2];
   logic         r_wptr;
   logic         r_rptr;
   logic [1:0]   r_count;
   logic         r_init;
   logic         w_push;
   logic         w_pop;

   assign o_ready = r_init & (r_count != 2'd2);
   assign o_valid = (r_count != 2'd0);
   assign o_data  = r_mem[r_rptr];
   assign w_push  = i_valid & o_ready;
   assign w_pop   = o_valid & i_ready;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_mem[0] <= '0;
         r_mem[1] <= '0;
         r_wptr   <= 1'b0;
         r_rptr   <= 1'b0;
         r_count  <= 2'd0;
         r_init   <= 1'b0;
      end else begin
         r_init <= 1'b1;
         if (w_push) begin
            r_mem[r_wptr] <= i_data;
            r_wptr        <= ~r_wptr;
         end
         if (w_pop)
            r_rptr <= ~r_rptr;
         r_count <= r_count + 2'(w_push) - 2'(w_pop);
      end
   end

endmodule

// File: rtl/noc_packet_sink.sv
// NoC receive endpoint: validates header/tail flits addressed to this node,
// streams data-flit payload to the local consumer and emits one status pulse
// per packet with error flags.
// Ports:
//   noc_clk, noc_rst            clock, asynchronous active-high reset
//   in_valid/in_ready/in_flit   router flit stream, in_is_header/in_is_tail tag it
//   out_valid/out_ready         payload stream, out_data/out_last
//   pkt_done                    one-cycle status pulse; pkt_src_x/y, pkt_type,
//                               pkt_len, pkt_err hold until the next pulse
// Build option NOC_SINK_STATS_EN adds saturating good_pkt_cnt/err_pkt_cnt.
//
// state     | meaning
// IDLE      | waiting for a header
// BODY      | header accepted, forwarding data flits until len reached
// WAIT_TAIL | all data seen, expecting the tail
// DROP      | packet already reported as bad, discarding up to its tail
module noc_packet_sink
   import noc_sink_pkg::*;
#(
   parameter int                DATA_W = 64,
   parameter int                ID_X_W = 4,
   parameter int                ID_Y_W = 4,
   parameter int                LEN_W  = 8,
   parameter logic [ID_X_W-1:0] X_ID   = '0,
   parameter logic [ID_Y_W-1:0] Y_ID   = '0
) (
   input  logic              noc_clk,
   input  logic              noc_rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_flit,
   input  logic              in_is_header,
   input  logic              in_is_tail,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   output logic              pkt_done,
   output logic [ID_X_W-1:0] pkt_src_x,
   output logic [ID_Y_W-1:0] pkt_src_y,
   output logic [1:0]        pkt_type,
   output logic [LEN_W-1:0]  pkt_len,
   output logic [3:0]        pkt_err
`ifdef NOC_SINK_STATS_EN
   ,
   output logic [15:0]       good_pkt_cnt,
   output logic [15:0]       err_pkt_cnt
`endif
);

   logic [7:0]        w_mark_h, w_mark_e;
   logic [ID_X_W-1:0] w_src_x, w_dst_x;
   logic [ID_Y_W-1:0] w_src_y, w_dst_y;
   logic [1:0]        w_type;
   logic [LEN_W-1:0]  w_len;
   logic              w_acc, w_is_hdr, w_is_tail;
   logic              w_hdr_ok, w_dst_ok, w_tail_ok;

   logic [1:0]        r_state, w_state_nxt;
   logic [LEN_W-1:0]  r_cnt, w_cnt_nxt, w_cnt_inc;
   logic [ID_X_W-1:0] r_src_x;
   logic [ID_Y_W-1:0] r_src_y;
   logic [1:0]        r_type;
   logic [LEN_W-1:0]  r_len;
   logic              w_done, w_push, w_last, w_latch, w_flit_fields;
   logic [3:0]        w_err;

   logic              r_pkt_done;
   logic [ID_X_W-1:0] r_pkt_src_x;
   logic [ID_Y_W-1:0] r_pkt_src_y;
   logic [1:0]        r_pkt_type;
   logic [LEN_W-1:0]  r_pkt_len;
   logic [3:0]        r_pkt_err;

   assign w_mark_h  = in_flit[POS_MARK_H +: 8];
   assign w_mark_e  = in_flit[POS_MARK_E +: 8];
   assign w_src_x   = in_flit[POS_SRC_X +: ID_X_W];
   assign w_src_y   = in_flit[POS_SRC_Y +: ID_Y_W];
   assign w_dst_x   = in_flit[POS_DST_X +: ID_X_W];
   assign w_dst_y   = in_flit[POS_DST_Y +: ID_Y_W];
   assign w_type    = in_flit[POS_TYPE +: 2];
   assign w_len     = in_flit[POS_LEN +: LEN_W];

   assign w_acc     = in_valid & in_ready;
   assign w_is_hdr  = in_is_header;
   // a flit tagged both header and tail is treated as a header
   assign w_is_tail = in_is_tail & ~in_is_header;
   assign w_hdr_ok  = (w_mark_h == HEAD_H) && (w_mark_e == HEAD_E);
   assign w_dst_ok  = (w_dst_x == X_ID) && (w_dst_y == Y_ID);
   assign w_tail_ok = (w_mark_h == TAIL_H) && (w_mark_e == TAIL_E) &&
                      (w_src_x == r_src_x) && (w_src_y == r_src_y);
   assign w_cnt_inc = r_cnt + LEN_W'(1);

   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_done        = 1'b0;
      w_err         = '0;
      w_push        = 1'b0;
      w_last        = 1'b0;
      w_latch       = 1'b0;
      w_flit_fields = 1'b0;
      if (w_acc) begin
         if (w_is_hdr && r_state != DROP) begin
            // a header mid-packet closes the current packet with err_tail and
            // is then judged as a fresh header in the same cycle
            w_done          = (r_state != IDLE);
            w_err[ERR_TAIL] = (r_state != IDLE);
            w_flit_fields   = (r_state == IDLE);
            if (!w_hdr_ok) begin
               w_done         = 1'b1;
               w_err[ERR_HDR] = 1'b1;
               w_state_nxt    = IDLE;
            end else if (!w_dst_ok) begin
               w_done          = 1'b1;
               w_err[ERR_DEST] = 1'b1;
               w_state_nxt     = DROP;
            end else begin
               w_latch     = 1'b1;
               w_cnt_nxt   = '0;
               w_state_nxt = (w_len == '0) ? WAIT_TAIL : BODY;
            end
         end else begin
            case (r_state)
               IDLE: begin
                  w_done         = 1'b1;
                  w_err[ERR_HDR] = 1'b1;
                  w_flit_fields  = 1'b1;
               end
               BODY: begin
                  if (w_is_tail) begin
                     w_done         = 1'b1;
                     w_err[ERR_LEN] = 1'b1;
                     w_state_nxt    = IDLE;
                  end else begin
                     w_push    = 1'b1;
                     w_cnt_nxt = w_cnt_inc;
                     if (w_cnt_inc == r_len) begin
                        w_last      = 1'b1;
                        w_state_nxt = WAIT_TAIL;
                     end
                  end
               end
               WAIT_TAIL: begin
                  w_done = 1'b1;
                  if (w_is_tail) begin
                     w_err[ERR_TAIL] = ~w_tail_ok;
                     w_state_nxt     = IDLE;
                  end else begin
                     w_err[ERR_LEN] = 1'b1;
                     w_state_nxt    = DROP;
                  end
               end
               default: begin
                  if (w_is_tail)
                     w_state_nxt = IDLE;
               end
            endcase
         end
      end
   end

   always_ff @(posedge noc_clk or posedge noc_rst) begin
      if (noc_rst) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_src_x     <= '0;
         r_src_y     <= '0;
         r_type      <= '0;
         r_len       <= '0;
         r_pkt_done  <= 1'b0;
         r_pkt_src_x <= '0;
         r_pkt_src_y <= '0;
         r_pkt_type  <= '0;
         r_pkt_len   <= '0;
         r_pkt_err   <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         r_pkt_done <= w_done;
         if (w_latch) begin
            r_src_x <= w_src_x;
            r_src_y <= w_src_y;
            r_type  <= w_type;
            r_len   <= w_len;
         end
         if (w_done) begin
            r_pkt_err   <= w_err;
            // errors found in IDLE describe the offending flit itself
            r_pkt_src_x <= w_flit_fields ? w_src_x : r_src_x;
            r_pkt_src_y <= w_flit_fields ? w_src_y : r_src_y;
            r_pkt_type  <= w_flit_fields ? w_type  : r_type;
            r_pkt_len   <= w_flit_fields ? w_len   : r_len;
         end
      end
   end

   assign pkt_done  = r_pkt_done;
   assign pkt_src_x = r_pkt_src_x;
   assign pkt_src_y = r_pkt_src_y;
   assign pkt_type  = r_pkt_type;
   assign pkt_len   = r_pkt_len;
   assign pkt_err   = r_pkt_err;

`ifdef NOC_SINK_STATS_EN
   logic [15:0] r_good_cnt, r_err_cnt;

   always_ff @(posedge noc_clk or posedge noc_rst) begin
      if (noc_rst) begin
         r_good_cnt <= '0;
         r_err_cnt  <= '0;
      end else if (w_done) begin
         if (w_err == '0) begin
            if (r_good_cnt != 16'hFFFF)
               r_good_cnt <= r_good_cnt + 16'd1;
         end else if (r_err_cnt != 16'hFFFF) begin
            r_err_cnt <= r_err_cnt + 16'd1;
         end
      end
   end

   assign good_pkt_cnt = r_good_cnt;
   assign err_pkt_cnt  = r_err_cnt;
`endif

   noc_skid_buffer #(
      .W (DATA_W + 1)
   ) u_skid (
      .i_clk   (noc_clk),
      .i_rst   (noc_rst),
      .i_valid (w_push),
      .i_data  ({w_last, in_flit}),
      .o_ready (in_ready),
      .o_valid (out_valid),
      .o_data  ({out_last, out_data}),
      .i_ready (out_ready)
   );

endmodule
